debug_slave_sysclk_cmdq: RTL and testbench
==========================================

Name: debug_slave_sysclk_cmdq

Overview:
System-clock side of the next-generation CPU JTAG debug slave. It is parametrised in IR width, data-register width, synchroniser depth and queue depth. It synchronises the update-DR and update-IR strobes from the TCK domain and captures the shifted data register with its IR code. Captured commands go into a first-word-fall-through queue with a valid/ready handshake, so back-to-back JTAG updates are not lost while the CPU debug logic is busy. A one-hot take_action pulse per IR code replaces the fixed per-instruction strobes.

Parameters:
IR_W, 2, instruction register width; number of action codes = 2**IR_W
DR_W, 38, data register width (captured sr / cmd_jdo)
SYNC_STAGES, 2, synchroniser flops per strobe, legal 2..4
QDEPTH, 4, command queue entries, power of two, legal 2..16

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ir_in  in  IR_W  IR value from TCK domain, held stable around update strobes
sr  in  DR_W  shifted DR contents from TCK domain, held stable around vs_udr
vs_udr  in  1  update-DR level strobe, asynchronous to clk
vs_uir  in  1  update-IR level strobe, asynchronous to clk
cmd_ready  in  1  consumer accepts head entry
ovf_clr  in  1  clears overflow sticky
cmd_valid  out  1  queue non-empty
cmd_ir  out  IR_W  IR code of head entry
cmd_jdo  out  DR_W  data of head entry
take_action  out  2**IR_W  one-hot pulse on pop, bit cmd_ir
ir_q  out  IR_W  last IR latched on update-IR
ir_update  out  1  one-cycle pulse when ir_q is loaded
level  out  clog2(QDEPTH)+1  current queue occupancy
overflow  out  1  sticky, an update-DR was dropped on full

Behaviour:
- Reset (async assert, sync-released by system): all synchroniser and edge flops 0, queue empty, level=0, cmd_valid=0, take_action=0, ir_q=0, ir_update=0, overflow=0. cmd_ir/cmd_jdo read as 0 while empty.
- Each strobe passes through SYNC_STAGES flops plus one delay flop. edge = sync_last & ~delay, so only rising edges act. Each high and low phase must last at least 1 clk period; TCK side guarantees this.
- Latency: vs_udr rises before clk edge 1 -> edge asserted after edge SYNC_STAGES -> entry written at edge SYNC_STAGES+1 -> cmd_valid high after edge SYNC_STAGES+1 (3 edges at default).
- Update-DR edge: write {ir_in, sr} sampled at the write edge into mem[wr_ptr], wr_ptr++, level++. sr and ir_in must be stable for SYNC_STAGES+2 clk after vs_udr rises.
- Update-IR edge: ir_q <= ir_in at the same relative edge; ir_update pulses for exactly 1 cycle. No queue entry.
- Both edges in the same cycle: both actions occur, and both use the same sampled ir_in.
- Queue is FWFT: cmd_ir/cmd_jdo = mem[rd_ptr] combinationally. Pop = cmd_valid & cmd_ready; rd_ptr++, level--.
- take_action[cmd_ir] = 1 in the pop cycle only (combinational from pop), all other bits 0. Never asserted when cmd_valid=0.
- Simultaneous push and pop: level unchanged, both pointers advance. This is legal when full (pop frees the slot, push accepted) and when empty (no pop possible, push only).
- Push while full without pop: entry dropped, queue contents and pointers unchanged, overflow <= 1.
- ovf_clr clears overflow. If a drop occurs in the same cycle, set wins.
- Pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. level saturates by construction (0..QDEPTH).
- cmd_ready while empty: no effect.
- Mid-operation reset: queue flushed, pending strobe edges lost; a strobe still high at release produces no edge until it goes low then high again (delay flop tracks sync).

Test Plan:
1. Reset, then pulse vs_udr with ir_in=2'b01, sr=38'h2A_DEADBEEF, cmd_ready=0 -> cmd_valid rises after the 3rd clk edge; cmd_ir=1, cmd_jdo=38'h2A_DEADBEEF, level=1.
2. From case 1, assert cmd_ready one cycle -> take_action=4'b0010 for exactly 1 cycle; cmd_valid=0, level=0.
3. Five vs_udr pulses (data 1..5), cmd_ready=0, QDEPTH=4 -> level=4, overflow=1; pops return 1,2,3,4; ovf_clr -> overflow=0.
4. Queue full, cmd_ready=1 held while a 5th update-DR edge arrives -> pop and push in the same cycle, level stays 4, no overflow, entry 5 is read last.
5. vs_uir and vs_udr rise together with ir_in=2'b11 -> ir_update 1 cycle, ir_q=3, queued cmd_ir=3.
6. Assert reset_n=0 while 2 entries are queued and vs_udr is high; release -> level=0, overflow=0, no entry until vs_udr falls and rises again; repeat with SYNC_STAGES=4, QDEPTH=8 for wrap over 20 pushes/pops, data order preserved.

Source files
------------

// File: rtl/debug_slave_sysclk_cmdq.sv
// System-clock side of the CPU JTAG debug slave.
// It synchronises the update-DR and update-IR strobes from the TCK domain
// and detects their rising edges. On each update-DR edge it pushes
// {ir_in, sr} into a first-word-fall-through command queue. On each
// update-IR edge it latches ir_in into ir_q. Popping the queue head
// produces a one-hot take_action pulse that selects the head's IR code.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   ir_in, sr         IR code and shifted DR from TCK domain (quasi-static)
//   vs_udr, vs_uir    update-DR / update-IR level strobes, async to clk
//   cmd_ready         consumer accepts head entry
//   ovf_clr           clears the overflow sticky
//   cmd_valid         queue non-empty
//   cmd_ir, cmd_jdo   head entry (zero while empty)
//   take_action       one-hot pulse on pop, bit cmd_ir
//   ir_q, ir_update   last IR latched on update-IR, one-cycle load pulse
//   level             queue occupancy 0..QDEPTH
//   overflow          sticky, an update-DR was dropped while full
module debug_slave_sysclk_cmdq #(
   parameter int IR_W        = 2,
   parameter int DR_W        = 38,
   parameter int SYNC_STAGES = 2,
   parameter int QDEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [IR_W-1:0]            ir_in,
   input  logic [DR_W-1:0]            sr,
   input  logic                       vs_udr,
   input  logic                       vs_uir,
   input  logic                       cmd_ready,
   input  logic                       ovf_clr,
   output logic                       cmd_valid,
   output logic [IR_W-1:0]            cmd_ir,
   output logic [DR_W-1:0]            cmd_jdo,
   output logic [(2**IR_W)-1:0]       take_action,
   output logic [IR_W-1:0]            ir_q,
   output logic                       ir_update,
   output logic [$clog2(QDEPTH):0]    level,
   output logic                       overflow
);

   localparam int NACT  = 2**IR_W;
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int SET_W = $clog2(SYNC_STAGES + 1);
   localparam int ENT_W = IR_W + DR_W;

   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic                   udr_dly;
   logic                   uir_dly;
   logic [SET_W-1:0]       settle;
   logic                   udr_edge;
   logic                   uir_edge;

   // The delay flops are held high while the synchronisers refill after
   // reset. As a result, a strobe that is already high at reset release
   // does not produce an edge. It must first go low and then high again.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_dly  <= 1'b0;
         uir_dly  <= 1'b0;
         settle   <= SET_W'(SYNC_STAGES);
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         if (settle != '0) begin
            settle  <= settle - SET_W'(1);
            udr_dly <= 1'b1;
            uir_dly <= 1'b1;
         end else begin
            udr_dly <= udr_sync[SYNC_STAGES-1];
            uir_dly <= uir_sync[SYNC_STAGES-1];
         end
      end
   end

   assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_dly;
   assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_dly;

   logic [ENT_W-1:0] mem [QDEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [ENT_W-1:0] head;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   assign full      = (level == LVL_W'(QDEPTH));
   assign cmd_valid = (level != '0);
   assign pop       = cmd_valid & cmd_ready;
   // A pop in the same cycle frees the slot, so a push while full is still accepted.
   assign push      = udr_edge & (~full | pop);
   assign drop      = udr_edge & full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ir_in, sr};
   end

   assign head    = mem[rd_ptr];
   assign cmd_ir  = cmd_valid ? head[ENT_W-1:DR_W] : '0;
   assign cmd_jdo = cmd_valid ? head[DR_W-1:0]     : '0;

   always_comb begin
      take_action = '0;
      if (pop) take_action = NACT'(1) << cmd_ir;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_q      <= '0;
         ir_update <= 1'b0;
      end else begin
         if (uir_edge) ir_q <= ir_in;
         ir_update <= uir_edge;
      end
   end

endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
module tb_debug_slave_sysclk_cmdq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        vs_udr, vs_uir, cmd_ready, ovf_clr;

   logic        valid_a, valid_b;
   logic [1:0]  cir_a, cir_b;
   logic [37:0] jdo_a, jdo_b;
   logic [3:0]  ta_a, ta_b;
   logic [1:0]  irq_a, irq_b;
   logic        iru_a, iru_b;
   logic [2:0]  lvl_a;
   logic [3:0]  lvl_b;
   logic        ovf_a, ovf_b;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b1;

   always #5 clk = ~clk;

   debug_slave_sysclk_cmdq #(.IR_W(2), .DR_W(38), .SYNC_STAGES(2), .QDEPTH(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
      .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
      .cmd_valid(valid_a), .cmd_ir(cir_a), .cmd_jdo(jdo_a), .take_action(ta_a),
      .ir_q(irq_a), .ir_update(iru_a), .level(lvl_a), .overflow(ovf_a));

   debug_slave_sysclk_cmdq #(.IR_W(2), .DR_W(38), .SYNC_STAGES(4), .QDEPTH(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
      .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
      .cmd_valid(valid_b), .cmd_ir(cir_b), .cmd_jdo(jdo_b), .take_action(ta_b),
      .ir_q(irq_b), .ir_update(iru_b), .level(lvl_b), .overflow(ovf_b));

   // Reference model. Instance 0 uses 2 sync stages and depth 4.
   // Instance 1 uses 4 sync stages and depth 8.
   // An update edge acts S+1 clocks after the sample that first saw the strobe high.
   // Both samples of that rise must have been taken after reset release.
   logic [39:0] mq [2][16];
   int          mcnt [2];
   logic        movf [2];
   logic [1:0]  mirq [2];
   logic        mirupd [2];
   int          npops [2];
   logic        hu [0:7];
   logic        hi [0:7];
   int          nsamp;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nsamp = 0;
         for (int j = 0; j < 8; j++) begin hu[j] = 1'b0; hi[j] = 1'b0; end
         for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; movf[i] = 1'b0; mirq[i] = 2'd0; mirupd[i] = 1'b0;
         end
      end else begin
         for (int j = 7; j > 0; j--) begin hu[j] = hu[j-1]; hi[j] = hi[j-1]; end
         hu[0] = vs_udr;
         hi[0] = vs_uir;
         nsamp++;
         for (int i = 0; i < 2; i++) begin
            int  s, d;
            bit  ue, ie, drop;
            s = (i == 0) ? 2 : 4;
            d = (i == 0) ? 4 : 8;
            ue = (nsamp >= s + 2) && hu[s] && !hu[s+1];
            ie = (nsamp >= s + 2) && hi[s] && !hi[s+1];
            if (mcnt[i] > 0 && cmd_ready) begin
               for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
               mcnt[i]--;
               npops[i]++;
            end
            drop = 1'b0;
            if (ue) begin
               if (mcnt[i] < d) begin mq[i][mcnt[i]] = {ir_in, sr}; mcnt[i]++; end
               else drop = 1'b1;
            end
            if (drop)         movf[i] = 1'b1;
            else if (ovf_clr) movf[i] = 1'b0;
            mirupd[i] = ie;
            if (ie) mirq[i] = ir_in;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input int i, input logic v, input logic [1:0] cir, input logic [37:0] jdo,
                      input logic [3:0] ta, input int lvl, input logic ovf,
                      input logic [1:0] irq, input logic iru);
      logic [39:0] hd;
      logic [3:0]  eta;
      hd  = (mcnt[i] > 0) ? mq[i][0] : 40'd0;
      eta = 4'd0;
      if (mcnt[i] > 0 && cmd_ready) eta[hd[39:38]] = 1'b1;
      chk($sformatf("m%0d_valid", i), 64'(v), 64'(mcnt[i] > 0));
      chk($sformatf("m%0d_cmd_ir", i), 64'(cir), 64'(hd[39:38]));
      chk($sformatf("m%0d_cmd_jdo", i), 64'(jdo), 64'(hd[37:0]));
      chk($sformatf("m%0d_take_action", i), 64'(ta), 64'(eta));
      chk($sformatf("m%0d_level", i), 64'(lvl), 64'(mcnt[i]));
      chk($sformatf("m%0d_overflow", i), 64'(ovf), 64'(movf[i]));
      chk($sformatf("m%0d_ir_q", i), 64'(irq), 64'(mirq[i]));
      chk($sformatf("m%0d_ir_update", i), 64'(iru), 64'(mirupd[i]));
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp(0, valid_a, cir_a, jdo_a, ta_a, int'(lvl_a), ovf_a, irq_a, iru_a);
         cmp(1, valid_b, cir_b, jdo_b, ta_b, int'(lvl_b), ovf_b, irq_b, iru_b);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // The strobe is high for one clock and then low long enough for the deeper instance to capture.
   task automatic pulse(input logic [1:0] ir, input logic [37:0] d);
      ir_in = ir; sr = d; vs_udr = 1'b1;
      tick();
      vs_udr = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      npops[0] = 0; npops[1] = 0;
      reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 0; vs_uir = 0; cmd_ready = 0; ovf_clr = 0;
      repeat (3) tick();
      chk("rst_valid", 64'(valid_a), 64'd0);
      chk("rst_level", 64'(lvl_a), 64'd0);
      chk("rst_overflow", 64'(ovf_a), 64'd0);
      chk("rst_ir_q", 64'(irq_a), 64'd0);
      chk("rst_take_action", 64'(ta_a), 64'd0);
      reset_n = 1'b1;
      repeat (5) tick();

      // Test 1: three-edge latency to cmd_valid.
      ir_in = 2'b01; sr = 38'h2A_DEADBEEF; vs_udr = 1'b1;
      tick();
      chk("lat_e1_valid", 64'(valid_a), 64'd0);
      tick();
      vs_udr = 1'b0;
      chk("lat_e2_valid", 64'(valid_a), 64'd0);
      tick();
      chk("lat_e3_valid", 64'(valid_a), 64'd1);
      chk("t1_cmd_ir", 64'(cir_a), 64'd1);
      chk("t1_cmd_jdo", 64'(jdo_a), 64'h2A_DEADBEEF);
      chk("t1_level", 64'(lvl_a), 64'd1);

      // Test 2: pop pulse.
      cmd_ready = 1'b1;
      #1;
      chk("t2_take_action", 64'(ta_a), 64'b0010);
      tick();
      cmd_ready = 1'b0;
      #1;
      chk("t2_ta_after", 64'(ta_a), 64'd0);
      chk("t2_valid", 64'(valid_a), 64'd0);
      chk("t2_level", 64'(lvl_a), 64'd0);
      repeat (4) tick();

      // Test 3: overflow on the 5th push.
      for (int k = 1; k <= 5; k++) pulse(2'b00, 38'(k));
      chk("t3_level", 64'(lvl_a), 64'd4);
      chk("t3_overflow", 64'(ovf_a), 64'd1);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("t3_pop%0d", k), 64'(jdo_a), 64'(k));
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
      end
      chk("t3_empty", 64'(valid_a), 64'd0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", 64'(ovf_a), 64'd0);
      cmd_ready = 1'b1; repeat (8) tick(); cmd_ready = 1'b0;

      // Test 4: push and pop together while full.
      for (int k = 11; k <= 14; k++) pulse(2'b00, 38'(k));
      sr = 38'd15; vs_udr = 1'b1;
      tick();
      vs_udr = 1'b0;
      tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("t4_level", 64'(lvl_a), 64'd4);
      chk("t4_overflow", 64'(ovf_a), 64'd0);
      repeat (3) tick();
      for (int k = 12; k <= 15; k++) begin
         chk($sformatf("t4_pop%0d", k), 64'(jdo_a), 64'(k));
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
      end
      chk("t4_empty", 64'(valid_a), 64'd0);
      cmd_ready = 1'b1; repeat (10) tick(); cmd_ready = 1'b0;

      // Test 5: update-IR and update-DR together.
      ir_in = 2'b11; sr = 38'h15; vs_udr = 1'b1; vs_uir = 1'b1;
      tick();
      vs_udr = 1'b0; vs_uir = 1'b0;
      tick();
      chk("t5_iru_early", 64'(iru_a), 64'd0);
      tick();
      chk("t5_ir_update", 64'(iru_a), 64'd1);
      chk("t5_ir_q", 64'(irq_a), 64'd3);
      chk("t5_cmd_ir", 64'(cir_a), 64'd3);
      tick();
      chk("t5_iru_once", 64'(iru_a), 64'd0);
      repeat (3) tick();
      cmd_ready = 1'b1; repeat (10) tick(); cmd_ready = 1'b0;

      // Test 6: reset with entries queued and the strobe held high.
      pulse(2'b10, 38'd21);
      pulse(2'b10, 38'd22);
      sr = 38'd23; vs_udr = 1'b1;
      tick(); tick();
      #1 reset_n = 1'b0;
      #1;
      chk("t6_rst_level", 64'(lvl_a), 64'd0);
      chk("t6_rst_valid", 64'(valid_a), 64'd0);
      tick(); tick();
      reset_n = 1'b1;
      repeat (10) tick();
      chk("t6_no_edge_a", 64'(lvl_a), 64'd0);
      chk("t6_no_edge_b", 64'(lvl_b), 64'd0);
      vs_udr = 1'b0;
      tick(); tick();
      pulse(2'b01, 38'd24);
      chk("t6_new_a", 64'(jdo_a), 64'd24);
      chk("t6_new_b", 64'(jdo_b), 64'd24);
      cmd_ready = 1'b1; repeat (4) tick(); cmd_ready = 1'b0;

      // Randomized phases. The first drains slowly and the second quickly, so both queues fill and wrap.
      npops[1] = 0;
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c < 400; c++) begin
            vs_udr    = ($urandom_range(0, 2) == 0);
            vs_uir    = ($urandom_range(0, 5) == 0);
            cmd_ready = (ph == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            ir_in     = 2'($urandom);
            sr        = {6'($urandom), 32'($urandom)};
            tick();
         end
      end
      chk("wrap_pops_b_ge20", 64'(npops[1] >= 20), 64'd1);

      cmp_en = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
